// File: rtl/medidor_pkg.sv
// Shared definitions for the range meter: FSM state codes and the ASCII
// constants used to build serial reports.
package medidor_pkg;

    // Report FSM state codes; the numeric values are visible on db_estado.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CARREGA = 3'd1,
        ST_PARTIDA = 3'd2,
        ST_ESPERA  = 3'd3,
        ST_PROXIMO = 3'd4,
        ST_FIM     = 3'd5
    } estado_t;

    // Upper three bits of an ASCII decimal digit ('0' = 7'h30).
    localparam logic [2:0] ASCII_PREFIXO_DIGITO = 3'b011;
    // Default report terminator '#'.
    localparam logic [6:0] ASCII_CERQUILHA      = 7'h23;
    // Default hit-report character 'A'.
    localparam logic [6:0] ASCII_A              = 7'h41;

    // Turn one BCD digit into its ASCII character.
    function automatic logic [6:0] ascii_digito(input logic [3:0] digito);
        return {ASCII_PREFIXO_DIGITO, digito};
    endfunction

endpackage

// File: rtl/contador_dwell.sv
// Saturating dwell counter: counts consecutive in-range cycles and issues a
// single completion pulse on the cycle the count sits at DWELL-1 for the
// first time in the current run.
module contador_dwell #(
    parameter int unsigned DWELL = 150_000_000,
    parameter int unsigned CNT_W = 28
) (
    input  logic clock,
    input  logic reset,
    input  logic zera_s,
    input  logic conta,
    output logic fim
);

    localparam logic [CNT_W-1:0] ULTIMO = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    // Remembers that this in-range run has already produced its pulse, so a
    // saturated counter does not keep re-firing fim.
    logic             cheio_q, cheio_d;

    // Completion pulse: at the terminal count, still counting, not yet fired.
    always_comb begin
        fim = conta && !zera_s && (cnt_q == ULTIMO) && !cheio_q;
    end

    // Next count: synchronous clear wins, otherwise increment up to ULTIMO.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        cnt_d   = cnt_q;
        cheio_d = cheio_q | fim;
        if (zera_s) begin
            cnt_d   = '0;
            cheio_d = 1'b0;
        end else if (conta && (cnt_q != ULTIMO)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter registers with synchronous reset.
    always_ff @(posedge clock) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            cnt_q   <= '0;
            cheio_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            cheio_q <= cheio_d;
        end
    end

endmodule

// File: rtl/medidor_faixa_n.sv
// Range meter: registers a packed-BCD measurement, flags when it sits inside
// [lowerL, upperL], latches a sticky hit after a dwell time, and on request
// sends a DIGITS+1 character ASCII report through a handshaked transmitter.
module medidor_faixa_n
    import medidor_pkg::*;
#(
    parameter int unsigned DIGITS = 3,
    parameter int unsigned DWELL  = 150_000_000,
    parameter int unsigned CNT_W  = 28,
    parameter logic [6:0]  TERM   = ASCII_CERQUILHA,
    parameter logic [6:0]  HIT    = ASCII_A
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  medida_valid,
    input  logic [4*DIGITS-1:0]   medida,
    input  logic [4*DIGITS-1:0]   upperL,
    input  logic [4*DIGITS-1:0]   lowerL,
    input  logic                  envia,
    input  logic                  limpa_acertou,
    input  logic                  tx_pronto,
    output logic                  tx_partida,
    output logic [6:0]            tx_dado,
    output logic                  dentro,
    output logic                  acertou,
    output logic                  ocupado,
    output logic                  fim_envio,
    output logic [4*DIGITS-1:0]   db_medida,
    output logic [2:0]            db_estado
);

    localparam int unsigned W     = 4 * DIGITS;
    localparam int unsigned IDX_W = $clog2(DIGITS + 1);
    // Index of the terminator, the last character of every report.
    localparam logic [IDX_W-1:0] IDX_TERM = IDX_W'(DIGITS);

    estado_t          estado_q, estado_d;
    logic [W-1:0]     db_medida_q, db_medida_d;
    logic             acertou_q, acertou_d;
    logic [IDX_W-1:0] indice_q, indice_d;
    logic [W-1:0]     snap_medida_q, snap_medida_d;
    logic             snap_acertou_q, snap_acertou_d;
    logic             fim_dwell;
    logic [3:0]       digito;
    logic [6:0]       caractere;

    // Inclusive unsigned compare; valid packed BCD orders like binary, and an
    // inverted window (lowerL > upperL) can never be satisfied.
    always_comb begin
        dentro = (db_medida_q >= lowerL) && (db_medida_q <= upperL);
    end

    contador_dwell #(
        .DWELL (DWELL),
        .CNT_W (CNT_W)
    ) u_contador_dwell (
        .clock  (clock),
        .reset  (reset),
        .zera_s (!dentro),
        .conta  (dentro),
        .fim    (fim_dwell)
    );

    // Measurement capture, sticky hit flag and report bookkeeping.
    always_comb begin
        db_medida_d    = medida_valid ? medida : db_medida_q;
        acertou_d      = acertou_q;
        if (limpa_acertou) begin
            acertou_d = 1'b0;
        end else if (fim_dwell) begin
            acertou_d = 1'b1;
        end
        indice_d       = indice_q;
        snap_medida_d  = snap_medida_q;
        snap_acertou_d = snap_acertou_q;
        case (estado_q)
            ST_CARREGA: begin
                // Freeze the report contents so later input changes cannot
                // leak into a report already under way.
                snap_medida_d  = db_medida_q;
                snap_acertou_d = acertou_q;
                indice_d       = '0;
            end
            ST_PROXIMO: begin
                if (indice_q != IDX_TERM) begin
                    indice_d = indice_q + IDX_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            db_medida_q    <= '0;
            acertou_q      <= 1'b0;
            indice_q       <= '0;
            snap_medida_q  <= '0;
            snap_acertou_q <= 1'b0;
        end else begin
            db_medida_q    <= db_medida_d;
            acertou_q      <= acertou_d;
            indice_q       <= indice_d;
            snap_medida_q  <= snap_medida_d;
            snap_acertou_q <= snap_acertou_d;
        end
    end

    // Character for the current index: hit marker or a digit, MSD first,
    // followed by the terminator.
    always_comb begin
        digito = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (indice_q == IDX_W'(k)) begin
                digito = snap_medida_q[4*(DIGITS-1-k) +: 4];
            end
        end
        if (indice_q == IDX_TERM) begin
            caractere = TERM;
        end else if (snap_acertou_q) begin
            caractere = HIT;
        end else begin
            caractere = ascii_digito(digito);
        end
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q <= ST_IDLE;
        end else begin
            estado_q <= estado_d;
        end
    end

    // FSM next state; envia outside IDLE and tx_pronto outside ESPERA are
    // dropped, and unused codes fall back to IDLE.
    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            ST_IDLE:    if (envia) estado_d = ST_CARREGA;
            ST_CARREGA: estado_d = ST_PARTIDA;
            ST_PARTIDA: estado_d = ST_ESPERA;
            ST_ESPERA:  if (tx_pronto) estado_d = ST_PROXIMO;
            ST_PROXIMO: estado_d = (indice_q == IDX_TERM) ? ST_FIM : ST_PARTIDA;
            ST_FIM:     estado_d = ST_IDLE;
            default:    estado_d = ST_IDLE;
        endcase
    end

    // FSM outputs: start strobe, character hold, busy and done pulse.
    always_comb begin
        tx_partida = 1'b0;
        tx_dado    = '0;
        fim_envio  = 1'b0;
        ocupado    = 1'b1;
        case (estado_q)
            ST_IDLE:    ocupado = 1'b0;
            ST_PARTIDA: begin
                tx_partida = 1'b1;
                tx_dado    = caractere;
            end
            ST_ESPERA:  tx_dado = caractere;
            ST_FIM:     fim_envio = 1'b1;
            default: ;
        endcase
    end

    assign acertou   = acertou_q;
    assign db_medida = db_medida_q;
    assign db_estado = estado_q;

endmodule
